// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM control decoder.
// MC_DECODER_EXTOPS_EN adds EOR, MOV and CMP to the data-processing decode.
package mc_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic [3:0] CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // arith: op produces meaningful C/V; nowb: flags-only, skip writeback
    typedef struct packed {
        logic [2:0] op;
        logic       legal;
        logic       arith;
        logic       nowb;
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{op: ALU_ADD, legal: 1'b1, arith: 1'b0, nowb: 1'b0};
        case (cmd)
            4'b0100: d.arith = 1'b1;
            4'b0010: begin d.op = ALU_SUB; d.arith = 1'b1; end
            4'b0000: d.op = ALU_AND;
            4'b1100: d.op = ALU_ORR;
`ifdef MC_DECODER_EXTOPS_EN
            4'b0001: d.op = ALU_EOR;
            4'b1101: d.op = ALU_MOV;
            4'b1010: begin d.op = ALU_SUB; d.arith = 1'b1; d.nowb = 1'b1; end
`endif
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/mc_condcheck.sv
// ARM condition-code evaluation against the {N,Z,C,V} flag register.
module mc_condcheck
    import mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        case (cond)
            CC_EQ:   condex = z;
            CC_NE:   condex = ~z;
            CC_CS:   condex = c;
            CC_CC:   condex = ~c;
            CC_MI:   condex = n;
            CC_PL:   condex = ~n;
            CC_VS:   condex = v;
            CC_VC:   condex = ~v;
            CC_HI:   condex = c & ~z;
            CC_LS:   condex = ~c | z;
            CC_GE:   condex = (n == v);
            CC_LT:   condex = (n != v);
            CC_GT:   condex = ~z & (n == v);
            CC_LE:   condex = z | (n != v);
            CC_AL:   condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_decoder.sv
// Multicycle ARM control FSM: sequencing, ALU decode, condition gating, flags.
// Optional EOR/MOV/CMP decode under MC_DECODER_EXTOPS_EN (see mc_pkg).
module mc_decoder
    import mc_pkg::*;
#(
    parameter int         ALUCTRL_W = 4,
    parameter logic [3:0] FLAG_RST  = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic                 Illegal,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
);
    state_t     state, state_n;
    logic       armed, condex, condexr, in_exec, upd_flags;
    logic [3:0] flags, rd_q;
    logic [1:0] op_q, op_c;
    logic [5:0] funct_q, funct_c;
    logic [2:0] alu_op;
    alu_dec_t   dec;

    // Fields are live while the IR is loaded/decoded, latched for later states.
    assign op_c      = (state == FETCH || state == DECODE) ? Op    : op_q;
    assign funct_c   = (state == FETCH || state == DECODE) ? Funct : funct_q;
    assign dec       = alu_decode(funct_c[4:1]);
    assign in_exec   = (state == EXECR) || (state == EXECI);
    assign upd_flags = armed && in_exec && funct_c[0] && condexr && dec.legal;

    mc_condcheck u_cond (.cond(Cond), .flags(flags), .condex(condex));

    // armed holds the FSM in a silent FETCH until the first edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            armed <= 1'b0;
        end else begin
            state <= armed ? state_n : FETCH;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            condexr <= 1'b0;
            flags   <= FLAG_RST;
            op_q    <= '0;
            funct_q <= '0;
            rd_q    <= '0;
        end else begin
            if (armed && state == DECODE) begin
                condexr <= condex;
                op_q    <= Op;
                funct_q <= Funct;
                rd_q    <= Rd;
            end
            if (upd_flags) begin
                flags[3:2] <= ALUFlags[3:2];
                if (dec.arith) flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_n = FETCH;
        case (state)
            FETCH:  state_n = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   state_n = MEMADR;
                    2'b00:   state_n = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_n = BRANCH;
                    default: state_n = UNKNOWN;
                endcase
            end
            MEMADR: state_n = funct_c[0] ? MEMRD : MEMWR;
            MEMRD:  state_n = MEMWB;
            EXECR, EXECI: state_n = (dec.legal && !dec.nowb) ? ALUWB : FETCH;
            default: state_n = FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        Illegal   = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        alu_op    = ALU_ADD;
        if (armed) begin
            case (state)
                FETCH: begin
                    IRWrite = 1'b1; PCWrite = 1'b1;
                    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU;
                end
                DECODE: begin
                    ALUSrcA = SRCA_PC; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALU;
                end
                MEMADR: ALUSrcB = SRCB_IMM;
                MEMRD:  AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = RES_DATA; RegWrite = condexr;
                end
                MEMWR: begin
                    AdrSrc = 1'b1; MemWrite = condexr;
                end
                EXECR, EXECI: begin
                    ALUSrcB = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                    if (dec.legal) alu_op = dec.op;
                    else           Illegal = 1'b1;
                end
                ALUWB: begin
                    RegWrite = condexr;
                    PCWrite  = condexr && (rd_q == 4'd15);
                end
                BRANCH: begin
                    ALUSrcB = SRCB_IMM; ResultSrc = RES_ALU; PCWrite = condexr;
                end
                UNKNOWN: Illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign ALUControl = ALUCTRL_W'(alu_op);
    assign RegSrc     = {(op_c == 2'b01) && !funct_c[0], op_c == 2'b10};
    assign ImmSrc     = op_c;
endmodule

// File: tb/tb_mc_decoder.sv
// Scoreboard bench for mc_decoder: per-cycle expected outputs are queued by
// the stimulus and popped by a negedge monitor.
module tb_mc_decoder;
    import mc_pkg::*;

    logic       clk, reset;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal;
    logic [1:0] RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] ALUControl;
    logic [19:0] outs;

    mc_decoder dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .Illegal(Illegal),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl)
    );

    assign outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, Illegal,
                   RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t q[$];
    int npass = 0;
    int ntot  = 0;
    logic [1:0] cur_regsrc, cur_immsrc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.nm, 32'(outs), 32'(e.v));
        end
    end

    task automatic push(input string nm, input logic pcw, input logic memw, input logic regw,
                        input logic irw, input logic adr, input logic ill,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
                        input logic [3:0] ac);
        exp_t e;
        e.nm = nm;
        e.v  = {pcw, memw, regw, irw, adr, ill, cur_regsrc, cur_immsrc, sa, sb, rs, ac};
        q.push_back(e);
    endtask

    task automatic fd(input string nm);
        push({nm, "_fetch"},  1, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b10, 4'd0);
        push({nm, "_decode"}, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 4'd0);
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                         input logic [3:0] r, input logic [3:0] af);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
        cur_regsrc = {(o == 2'b01) && !f[0], o == 2'b10};
        cur_immsrc = o;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        issue(4'b1110, 2'b00, 6'b000000, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state", 32'(dut.state), 32'(FETCH));
        chk("rst_we", 32'({PCWrite, MemWrite, RegWrite, IRWrite, Illegal}), 32'd0);
        chk("rst_flags", 32'(dut.flags), 32'h0);
        reset = 1'b0;
        run(1);

        issue(4'b0000, 2'b10, 6'b100000, 4'd0, 4'd0);            // BEQ, Z=0
        fd("beq_nt");
        push("beq_nt_br", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0);
        run(3);

        issue(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0110);         // ADDS r2
        fd("adds");
        push("adds_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("adds_wb", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);
        chk("adds_flags", 32'(dut.flags), 32'h6);

        issue(4'b0000, 2'b10, 6'b100000, 4'd0, 4'd0);            // BEQ, Z=1
        fd("beq_t");
        push("beq_t_br", 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0);
        run(3);

        issue(4'b1110, 2'b01, 6'b011000, 4'd3, 4'd0);            // STR
        fd("str");
        push("str_ma", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0);
        push("str_mw", 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);

        issue(4'b1110, 2'b01, 6'b011001, 4'd15, 4'd0);           // LDR r15
        fd("ldr15");
        push("ldr15_ma", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0);
        push("ldr15_mr", 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("ldr15_wb", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'd0);
        run(5);

        issue(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b1111);        // ADD r15, no S
        fd("dp15");
        push("dp15_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("dp15_wb", 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);
        chk("dp15_flags", 32'(dut.flags), 32'h6);

        issue(4'b1110, 2'b00, 6'b111000, 4'd4, 4'd0);            // ORR imm
        fd("orri");
        push("orri_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd3);
        push("orri_wb", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);

        issue(4'b1110, 2'b00, 6'b000100, 4'd4, 4'd0);            // SUB reg
        fd("sub");
        push("sub_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd1);
        push("sub_wb", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);

        issue(4'b0001, 2'b00, 6'b000000, 4'd5, 4'd0);            // ANDNE, Z=1
        fd("andne");
        push("andne_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd2);
        push("andne_wb", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);

        issue(4'b1110, 2'b11, 6'b000000, 4'd0, 4'd0);            // Op=11
        fd("op11");
        push("op11_unk", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0);
        run(3);

        issue(4'b1110, 2'b00, 6'b001101, 4'd1, 4'b1111);         // unmapped cmd 0110
        fd("unmap");
        push("unmap_ex", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0);
        run(3);
        chk("unmap_flags", 32'(dut.flags), 32'h6);

        issue(4'b1110, 2'b00, 6'b010101, 4'd1, 4'b1001);         // CMP
        fd("cmp");
`ifdef MC_DECODER_EXTOPS_EN
        push("cmp_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd1);
        run(3);
        chk("cmp_flags", 32'(dut.flags), 32'h9);
`else
        push("cmp_ex", 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0);
        run(3);
        chk("cmp_flags", 32'(dut.flags), 32'h6);
`endif

        issue(4'b1111, 2'b00, 6'b001000, 4'd6, 4'd0);            // Cond=1111 never
        fd("nv");
        push("nv_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("nv_wb", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);

        issue(4'b1110, 2'b00, 6'b000001, 4'd7, 4'b0011);         // ANDS: NZ only
        fd("ands");
        push("ands_ex", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd2);
        push("ands_wb", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(4);
`ifdef MC_DECODER_EXTOPS_EN
        chk("ands_flags", 32'(dut.flags), 32'h1);
`else
        chk("ands_flags", 32'(dut.flags), 32'h2);
`endif

        issue(4'b1110, 2'b01, 6'b011001, 4'd8, 4'd0);            // LDR, reset in MEMRD
        fd("ldr_rst");
        push("ldr_rst_ma", 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 4'd0);
        run(3);
        chk("ldr_rst_pre", 32'(dut.state), 32'(MEMRD));
        reset = 1'b1;
        #1;
        chk("ldr_rst_state", 32'(dut.state), 32'(FETCH));
        chk("ldr_rst_we", 32'({PCWrite, MemWrite, RegWrite, IRWrite, Illegal}), 32'd0);
        chk("ldr_rst_flags", 32'(dut.flags), 32'h0);
        push("ldr_rst_idle0", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("ldr_rst_idle1", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        push("ldr_rst_idle2", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0);
        run(2);
        reset = 1'b0;
        run(1);

        issue(4'b1110, 2'b10, 6'b100000, 4'd0, 4'd0);            // B after reset
        fd("b_post");
        push("b_post_br", 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0);
        run(3);

        run(2);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
